// File: rtl/xram_arb.sv
// Two-master round-robin arbiter in front of a single XRAM port (m0 copy engine, m1 crypto).
// Define XRAM_ARB_TIMEOUT_EN to abort stalled grants after TIMEOUT cycles and flag err.
module xram_arb #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m0_data_in,
  input  logic [7:0]  m1_data_in,
  input  logic        m0_stb,
  input  logic        m1_stb,
  input  logic        m0_wr,
  input  logic        m1_wr,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [7:0]  m0_data_out,
  output logic [7:0]  m1_data_out,
  output logic [15:0] xram_addr,
  output logic [7:0]  xram_data_out,
  output logic        xram_stb,
  output logic        xram_wr,
  input  logic [7:0]  xram_data_in,
  input  logic        xram_ack,
  output logic [1:0]  owner,
  input  logic        err_clr,
  output logic        err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        last_q, last_d;  // 1: m1 was granted most recently
  logic        busy, own_stb, oth_stb, beat, to_fire, pick_m0;
  logic [7:0]  rdata;

`ifdef XRAM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  assign to_fire = busy && own_stb && !xram_ack && (cnt_q == TIMEOUT);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (!busy || beat || (owner_d != owner_q)) begin
        cnt_q <= 8'd0;
      end else if (!xram_ack) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // A timeout on the same edge as err_clr wins.
      if (to_fire) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  localparam logic [7:0] unused_timeout = TIMEOUT;
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign to_fire        = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    busy    = (state_q == StBusy);
    own_stb = (owner_q[0] && m0_stb) || (owner_q[1] && m1_stb);
    oth_stb = (owner_q[0] && m1_stb) || (owner_q[1] && m0_stb);
    beat    = busy && own_stb && (xram_ack || to_fire);
    rdata   = xram_ack ? xram_data_in : 8'hFF;

    m0_ack      = beat && owner_q[0];
    m1_ack      = beat && owner_q[1];
    m0_data_out = m0_ack ? rdata : 8'h00;
    m1_data_out = m1_ack ? rdata : 8'h00;
    owner       = owner_q;

    xram_addr     = 16'h0000;
    xram_data_out = 8'h00;
    xram_stb      = 1'b0;
    xram_wr       = 1'b0;
    if (busy && owner_q[0]) begin
      xram_addr     = m0_addr;
      xram_data_out = m0_data_in;
      xram_stb      = m0_stb;
      xram_wr       = m0_wr;
    end else if (busy && owner_q[1]) begin
      xram_addr     = m1_addr;
      xram_data_out = m1_data_in;
      xram_stb      = m1_stb;
      xram_wr       = m1_wr;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    // On a tie the master not granted last wins.
    pick_m0 = (m0_stb && m1_stb) ? last_q : m0_stb;
    unique case (state_q)
      StIdle: begin
        if (m0_stb || m1_stb) begin
          state_d = StBusy;
          owner_d = pick_m0 ? 2'b01 : 2'b10;
          last_d  = !pick_m0;
        end
      end
      StBusy: begin
        if (!own_stb) begin
          state_d = StIdle;
          owner_d = 2'b00;
          last_d  = owner_q[1];
        end else if (beat && oth_stb) begin
          owner_d = ~owner_q;
          last_d  = owner_q[0];
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_xram_arb.sv
// Directed, table-driven bench for xram_arb: single-master beats, writes, stb drop,
// tie alternation, mid-burst reset and (when XRAM_ARB_TIMEOUT_EN is defined) timeout.
module tb_xram_arb;

  logic        clk, rst;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_data_in, m1_data_in;
  logic        m0_stb, m1_stb, m0_wr, m1_wr;
  logic        m0_ack, m1_ack;
  logic [7:0]  m0_data_out, m1_data_out;
  logic [15:0] xram_addr;
  logic [7:0]  xram_data_out;
  logic        xram_stb, xram_wr;
  logic [7:0]  xram_data_in;
  logic        xram_ack;
  logic [1:0]  owner;
  logic        err_clr, err;

  int total = 0;
  int bad   = 0;

  xram_arb #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
    .m0_stb(m0_stb), .m1_stb(m1_stb), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out),
    .xram_stb(xram_stb), .xram_wr(xram_wr),
    .xram_data_in(xram_data_in), .xram_ack(xram_ack),
    .owner(owner), .err_clr(err_clr), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " owner"}, 32'(owner), 32'h0);
    chk({tag, " xram_stb"}, 32'(xram_stb), 32'h0);
    chk({tag, " xram_addr"}, 32'(xram_addr), 32'h0);
    chk({tag, " m0_ack"}, 32'(m0_ack), 32'h0);
    chk({tag, " m1_ack"}, 32'(m1_ack), 32'h0);
  endtask

  typedef struct {
    logic        s0, s1, w1, ack;
    logic [7:0]  din;
    logic [1:0]  owner;
    logic        xstb;
    logic [15:0] xaddr;
    logic        xwr;
    logic [7:0]  xdata;
    logic        a0, a1;
    logic [7:0]  d0, d1;
  } vec_t;

  vec_t vecs[14];

  initial begin
    //             s0 s1 w1 ack din    owner xstb xaddr     xwr xdata  a0 a1 d0     d1
    vecs[0]  = '{1, 0, 0, 1, 8'hA5, 2'b00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[1]  = '{1, 0, 0, 1, 8'hA5, 2'b01, 1, 16'h0100, 0, 8'h11, 1, 0, 8'hA5, 8'h00};
    vecs[2]  = '{1, 0, 0, 1, 8'hA5, 2'b01, 1, 16'h0100, 0, 8'h11, 1, 0, 8'hA5, 8'h00};
    vecs[3]  = '{0, 0, 0, 1, 8'hA5, 2'b01, 0, 16'h0100, 0, 8'h11, 0, 0, 8'h00, 8'h00};
    vecs[4]  = '{0, 0, 0, 0, 8'h00, 2'b00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[5]  = '{0, 1, 1, 0, 8'h00, 2'b00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[6]  = '{0, 1, 1, 0, 8'h00, 2'b10, 1, 16'hFE00, 1, 8'h3C, 0, 0, 8'h00, 8'h00};
    vecs[7]  = '{0, 1, 1, 1, 8'h5A, 2'b10, 1, 16'hFE00, 1, 8'h3C, 0, 1, 8'h00, 8'h5A};
    vecs[8]  = '{0, 0, 0, 1, 8'h5A, 2'b10, 0, 16'hFE00, 0, 8'h3C, 0, 0, 8'h00, 8'h00};
    vecs[9]  = '{0, 0, 0, 0, 8'h00, 2'b00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[10] = '{1, 0, 0, 0, 8'h00, 2'b00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[11] = '{1, 0, 0, 0, 8'h00, 2'b01, 1, 16'h0100, 0, 8'h11, 0, 0, 8'h00, 8'h00};
    vecs[12] = '{0, 0, 0, 0, 8'h00, 2'b01, 0, 16'h0100, 0, 8'h11, 0, 0, 8'h00, 8'h00};
    vecs[13] = '{0, 0, 0, 0, 8'h00, 2'b00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 8'h00};

    rst = 1'b0;
    m0_addr = 16'h0100; m0_data_in = 8'h11; m0_wr = 1'b0; m0_stb = 1'b0;
    m1_addr = 16'hFE00; m1_data_in = 8'h3C; m1_wr = 1'b0; m1_stb = 1'b0;
    xram_ack = 1'b0; xram_data_in = 8'h00; err_clr = 1'b0;
    #12;
    chk_quiet("reset");
    chk("reset err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      m0_stb = vecs[i].s0; m1_stb = vecs[i].s1; m1_wr = vecs[i].w1;
      xram_ack = vecs[i].ack; xram_data_in = vecs[i].din;
      #1;
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].owner));
      chk($sformatf("v%0d xram_stb", i), 32'(xram_stb), 32'(vecs[i].xstb));
      chk($sformatf("v%0d xram_addr", i), 32'(xram_addr), 32'(vecs[i].xaddr));
      chk($sformatf("v%0d xram_wr", i), 32'(xram_wr), 32'(vecs[i].xwr));
      chk($sformatf("v%0d xram_data_out", i), 32'(xram_data_out), 32'(vecs[i].xdata));
      chk($sformatf("v%0d m0_ack", i), 32'(m0_ack), 32'(vecs[i].a0));
      chk($sformatf("v%0d m1_ack", i), 32'(m1_ack), 32'(vecs[i].a1));
      chk($sformatf("v%0d m0_data_out", i), 32'(m0_data_out), 32'(vecs[i].d0));
      chk($sformatf("v%0d m1_data_out", i), 32'(m1_data_out), 32'(vecs[i].d1));
      chk($sformatf("v%0d err", i), 32'(err), 32'h0);
      @(posedge clk); #1;
    end

    // Tie from reset: m0 first, then strict alternation on each ack.
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
    m0_stb = 1'b1; m1_stb = 1'b1; m1_wr = 1'b0; xram_ack = 1'b1; xram_data_in = 8'h77;
    #1;
    chk("tie idle owner", 32'(owner), 32'h0);
    chk("tie idle m0_ack", 32'(m0_ack), 32'h0);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      chk($sformatf("tie b%0d owner", b), 32'(owner), (b % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("tie b%0d m0_ack", b), 32'(m0_ack), (b % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("tie b%0d m1_ack", b), 32'(m1_ack), (b % 2 == 0) ? 32'h0 : 32'h1);
      chk($sformatf("tie b%0d m0_data", b), 32'(m0_data_out), (b % 2 == 0) ? 32'h77 : 32'h0);
      chk($sformatf("tie b%0d m1_data", b), 32'(m1_data_out), (b % 2 == 0) ? 32'h0 : 32'h77);
    end

    // Reset in the middle of the burst; outputs drop at once and no ack leaks.
    #1;
    rst = 1'b0;
    #1;
    chk_quiet("midrst now");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_quiet($sformatf("midrst c%0d", c));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst owner", 32'(owner), 32'h0);
    @(posedge clk); #1;
    chk("postrst grant m0", 32'(owner), 32'h1);
    chk("postrst xram_stb", 32'(xram_stb), 32'h1);
    m0_stb = 1'b0; m1_stb = 1'b0; xram_ack = 1'b0;
    @(posedge clk); #1;
    chk("drain owner", 32'(owner), 32'h0);

`ifdef XRAM_ARB_TIMEOUT_EN
    // TIMEOUT=4: four silent BUSY cycles, then an aborting ack with FF.
    m0_stb = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to wait%0d m0_ack", c), 32'(m0_ack), 32'h0);
      chk($sformatf("to wait%0d err", c), 32'(err), 32'h0);
      @(posedge clk); #1;
    end
    chk("to fire m0_ack", 32'(m0_ack), 32'h1);
    chk("to fire m0_data", 32'(m0_data_out), 32'hFF);
    @(posedge clk); #1;
    chk("to err set", 32'(err), 32'h1);
    chk("to m0_ack cleared", 32'(m0_ack), 32'h0);
    chk("to owner kept", 32'(owner), 32'h1);
    m0_stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("to err sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("to err cleared", 32'(err), 32'h0);
`else
    // Without the timeout a stalled grant waits indefinitely and err stays 0.
    m0_stb = 1'b1;
    err_clr = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
    end
    chk("stall owner", 32'(owner), 32'h1);
    chk("stall m0_ack", 32'(m0_ack), 32'h0);
    chk("stall err", 32'(err), 32'h0);
    m0_stb = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xram_arb.md
XRAM_ARB -- requirements
Module: xram_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: cycles a BUSY grant waits for xram_ack before abort; used only with XRAM_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports m0_addr/m1_addr  input  16  master XRAM address; m0 is the mem_wr copy engine, m1 the crypto engine.
REQ-005 SHALL have ports m0_data_in/m1_data_in  input  8  master write data.
REQ-006 SHALL have ports m0_stb/m1_stb and m0_wr/m1_wr  input  1  request strobe and write qualifier.
REQ-007 SHALL have ports m0_ack/m1_ack  output  1  per-master transfer complete.
REQ-008 SHALL have ports m0_data_out/m1_data_out  output  8  read data returned to the master.
REQ-009 SHALL have ports xram_addr (16), xram_data_out (8), xram_stb (1), xram_wr (1)  output  forwarded request to XRAM.
REQ-010 SHALL have ports xram_data_in (8) and xram_ack (1)  input  XRAM read data and completion.
REQ-011 SHALL have port owner  output  2  one-hot current grant: 01 = m0, 10 = m1, 00 = none.
REQ-012 SHALL have ports err_clr  input  1 and err  output  1  sticky timeout flag and its clear.

Function
REQ-013 SHALL implement states IDLE (owner 00) and BUSY (owner one-hot).
REQ-014 IDLE: if any mN_stb is high, SHALL enter BUSY next cycle granting per round-robin (REQ-015); no xram_stb in IDLE.
REQ-015 Round-robin: SHALL grant the master not granted most recently when both request; last_grant resets to m1, so m0 wins the first tie.
REQ-016 BUSY: xram_addr, xram_data_out, xram_wr SHALL combinationally follow the owner's addr/data_in/wr; xram_stb = owner's stb.
REQ-017 Not BUSY: xram_addr, xram_data_out SHALL be 0 and xram_stb, xram_wr 0.
REQ-018 mN_ack SHALL equal xram_ack && owner==N && mN_stb; the non-owner's ack SHALL be 0.
REQ-019 mN_data_out SHALL equal xram_data_in when mN_ack is high, else 8'h00.
REQ-020 On an acked beat the grant SHALL be re-evaluated for the next cycle with no bubble: the other master if its stb is high, else the same master if its stb is still high, else IDLE.
REQ-021 If the owner drops stb before ack, SHALL return to IDLE next cycle and record it as last_grant.
REQ-022 Latency: request from IDLE sees xram_stb exactly 1 cycle after mN_stb rises; back-to-back beats of one master with no contention SHALL sustain one beat per xram_ack.
REQ-023 xram_ack while not BUSY, or while owner's stb is low, SHALL be ignored.

Reset
REQ-024 On rst low, asynchronously: state IDLE, owner 00, last_grant m1, err 0, timeout counter 0; all outputs 0 while rst is low.
REQ-025 Reset mid-transfer SHALL abort with no ack issued; operation resumes on the first rising edge after rst goes high.

Configuration
REQ-026 Macro XRAM_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on grant change or ack and increment each BUSY cycle without xram_ack.
REQ-027 On reaching TIMEOUT: SHALL pulse owner's mN_ack one cycle with mN_data_out 8'hFF, set err, and re-arbitrate as in REQ-020.
REQ-028 err SHALL be sticky until err_clr is high on a clock edge; a simultaneous set has priority over clear.
REQ-029 Macro undefined: no counter SHALL exist, err SHALL be constant 0, err_clr ignored, and BUSY waits indefinitely.

Verification
REQ-030 m0 only, stb high, addr 16'h0100, wr 0, XRAM acks every cycle returning 8'hA5: xram_stb 1 cycle after m0_stb; m0_ack each cycle; m0_data_out 8'hA5.
REQ-031 m0 and m1 assert stb the same cycle from reset: owner 01 first; after the ack owner 10; accesses alternate 01/10 while both hold stb.
REQ-032 m1 owns, writes 8'h3C to 16'hFE00 with wr 1, m0 stb low: xram_wr 1, xram_data_out 8'h3C, m0_ack never high.
REQ-033 m0 drops stb while BUSY with no ack: IDLE next cycle, xram_stb 0, owner 00.
REQ-034 With XRAM_ARB_TIMEOUT_EN, TIMEOUT 4, xram_ack held 0: after 4 BUSY cycles m0_ack pulses, m0_data_out 8'hFF, err 1 until err_clr.
REQ-035 rst pulsed low mid-burst: all outputs 0 immediately; no ack issued; new grant follows REQ-015.
